song_player: RTL

- Downstream consumer of the song editor's two 32-bit lane patterns (bit i = note at beat i; note1 = lane 0, note2 = lane 1).
- On start it snapshots both patterns, counts in a lead-in, then steps beat_idx 0..31 at a fixed tempo.
- Scores the player's lane button pulses against the expected notes: hit, wrong press, or missed.
- Feeds the display and score logic with the current beat, expected lanes, score and combo.

---
 rtl/song_pkg.sv | 15 +
 rtl/song_player_beat_timer.sv | 28 ++
 rtl/song_player.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// Shared types and sizes for the song player.
// Pattern bit i holds the note at beat i.
package song_pkg;
  localparam int SONG_LEN = 32;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    DONE
  } player_state_t;

  typedef logic [SONG_LEN-1:0] lane_pattern_t;
endpackage

// File: rtl/song_player_beat_timer.sv
// Beat tick counter: counts 0..BEAT_TICKS-1 while enabled.
// beat_tick is high during the terminal-count cycle.
module beat_timer #(
  parameter int BEAT_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic beat_tick
);
  localparam int CW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [CW-1:0] TERM = CW'(BEAT_TICKS - 1);

  logic [CW-1:0] cnt;

  assign beat_tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= beat_tick ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/song_player.sv
// Song player: lead-in countdown, 32-beat playback, hit/miss scoring.
// Optional pause input enabled by SONG_PLAYER_PAUSE_EN.
module song_player
  import song_pkg::*;
#(
  parameter int BEAT_TICKS = 1_000_000,
  parameter int LEAD_BEATS = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [31:0]        note1,
  input  logic [31:0]        note2,
  input  logic [1:0]         hit,
`ifdef SONG_PLAYER_PAUSE_EN
  input  logic               pause_btn,
`endif
  output logic [IDX_W-1:0]   beat_idx,
  output logic [1:0]         lane_now,
  output logic               beat_tick,
  output logic               playing,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [5:0]         combo,
  output logic               hit_ok,
  output logic               miss
);
  localparam int LW = (LEAD_BEATS > 1) ? $clog2(LEAD_BEATS) : 1;
  localparam logic [LW-1:0] LEAD_LAST = LW'(LEAD_BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(SONG_LEN - 1);

  player_state_t state, state_nx;
  lane_pattern_t sh1, sh1_nx, sh2, sh2_nx;
  logic [IDX_W-1:0]   beat_nx;
  logic [LW-1:0]      lead, lead_nx;
  logic [SCORE_W-1:0] score_nx;
  logic [5:0]         combo_nx;
  logic [1:0]         used, used_nx;
  logic               hit_ok_nx, miss_nx;
  logic               paused, go, tmr_en;
  logic [1:0]         expd, good, bad;
  logic [SCORE_W:0]   ssum;
  logic [6:0]         csum;

  assign go = start && (state == IDLE || state == DONE);
  assign tmr_en = (state == COUNTDOWN || state == PLAY) && !paused;

  beat_timer #(
    .BEAT_TICKS(BEAT_TICKS)
  ) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (go),
    .en       (tmr_en),
    .beat_tick(beat_tick)
  );

  assign expd = {sh2[beat_idx], sh1[beat_idx]};
  // a lane scores only once per beat; later presses count as wrong
  assign good = hit & expd & ~used;
  assign bad  = hit & ~(expd & ~used);
  assign ssum = {1'b0, score} + (SCORE_W+1)'(good[0])
              + (SCORE_W+1)'(good[1]);
  assign csum = {1'b0, combo} + 7'(good[0]) + 7'(good[1]);

  assign playing  = (state == PLAY);
  assign done     = (state == DONE);
  assign lane_now = playing ? expd : 2'b00;

  always_comb begin
    state_nx  = state;
    beat_nx   = beat_idx;
    lead_nx   = lead;
    sh1_nx    = sh1;
    sh2_nx    = sh2;
    score_nx  = score;
    combo_nx  = combo;
    used_nx   = used;
    hit_ok_nx = 1'b0;
    miss_nx   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = COUNTDOWN;
          sh1_nx   = note1;
          sh2_nx   = note2;
          score_nx = '0;
          combo_nx = '0;
          used_nx  = '0;
          lead_nx  = '0;
        end
      end
      COUNTDOWN: begin
        if (beat_tick) begin
          if (lead == LEAD_LAST) begin
            state_nx = PLAY;
            beat_nx  = '0;
            lead_nx  = '0;
          end else begin
            lead_nx = lead + LW'(1);
          end
        end
      end
      PLAY: begin
        if (!paused) begin
          score_nx  = ssum[SCORE_W] ? '1 : ssum[SCORE_W-1:0];
          combo_nx  = (|bad) ? 6'd0 : (csum[6] ? 6'h3F : csum[5:0]);
          used_nx   = used | good;
          hit_ok_nx = |good;
          if (beat_tick) begin
            if (|(expd & ~used_nx)) begin
              combo_nx = '0;
              miss_nx  = 1'b1;
            end
            used_nx = '0;
            if (beat_idx == LAST_BEAT) begin
              state_nx = DONE;
            end else begin
              beat_nx = beat_idx + IDX_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_idx <= '0;
      lead     <= '0;
      sh1      <= '0;
      sh2      <= '0;
      score    <= '0;
      combo    <= '0;
      used     <= '0;
      hit_ok   <= 1'b0;
      miss     <= 1'b0;
    end else begin
      beat_idx <= beat_nx;
      lead     <= lead_nx;
      sh1      <= sh1_nx;
      sh2      <= sh2_nx;
      score    <= score_nx;
      combo    <= combo_nx;
      used     <= used_nx;
      hit_ok   <= hit_ok_nx;
      miss     <= miss_nx;
    end
  end

`ifdef SONG_PLAYER_PAUSE_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      paused <= 1'b0;
    end else if (state_nx != PLAY) begin
      paused <= 1'b0;
    end else if (state == PLAY && pause_btn) begin
      paused <= ~paused;
    end
  end
`else
  assign paused = 1'b0;
`endif
endmodule
